// File: rtl/arp_rx.sv
// arp_rx: GMII RX ARP parser, hands the sender MAC/IP to MAC control.
// Optional build macro ARP_RX_CRC_EN adds FCS (CRC-32) checking.
module arp_rx #(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
    parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_00_02,
    parameter logic [10:0] MAX_LEN   = 11'd1518
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        e_rxdv,
    input  logic [7:0]  e_rxd,
    input  logic        e_rxer,
    output logic        fs_recv,
    input  logic        fd_recv,
    output logic        arp_op,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic [15:0] drop_cnt
);
`ifdef ARP_RX_CRC_EN
    localparam logic [10:0] MIN_LEN = 11'd46;
`else
    localparam logic [10:0] MIN_LEN = 11'd42;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_PREAM, S_BODY, S_CHK, S_HOLD, S_SKIP
    } state_t;

    state_t      r_state, w_next;
    logic [10:0] r_bcnt;
    logic        r_bad, r_bc, r_uc, r_op;
    logic [47:0] r_sha;
    logic [31:0] r_spa;
    logic        w_sfd, w_take, w_drop, w_accept, w_clr;
    logic        w_good, w_mis, w_crc_ok;
    logic [2:0]  w_maci;
    logic [1:0]  w_ipi;
    logic [7:0]  w_macb, w_ipb;

`ifdef ARP_RX_CRC_EN
    logic [31:0] r_crc;

    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] v;
        v = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
        return v;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_crc <= '1;
        else if (w_sfd)
            r_crc <= '1;
        else if (w_take)
            r_crc <= crc_step(r_crc, e_rxd);
    end

    // Running CRC over data plus FCS lands on the fixed residue
    assign w_crc_ok = (r_crc == 32'hDEBB20E3);
`else
    assign w_crc_ok = 1'b1;
`endif

    // Expected byte for the current offset of fixed-value fields
    always_comb begin
        w_maci = r_bcnt[2:0];
        w_ipi  = 2'(r_bcnt - 11'd38);
        w_macb = 8'(LOCAL_MAC >> {3'd5 - w_maci, 3'b000});
        w_ipb  = 8'(LOCAL_IP >> {2'd3 - w_ipi, 3'b000});
        w_mis  = 1'b0;
        case (r_bcnt)
            11'd12:                 w_mis = (e_rxd != 8'h08);
            11'd13:                 w_mis = (e_rxd != 8'h06);
            11'd14, 11'd17, 11'd20: w_mis = (e_rxd != 8'h00);
            11'd15:                 w_mis = (e_rxd != 8'h01);
            11'd16:                 w_mis = (e_rxd != 8'h08);
            11'd18:                 w_mis = (e_rxd != 8'h06);
            11'd19:                 w_mis = (e_rxd != 8'h04);
            11'd21:                 w_mis = (e_rxd != 8'h01) && (e_rxd != 8'h02);
            11'd38, 11'd39,
            11'd40, 11'd41:         w_mis = (e_rxd != w_ipb);
            default:                w_mis = 1'b0;
        endcase
    end

    assign w_good = (r_bc | r_uc) & ~r_bad & w_crc_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_sfd    = 1'b0;
        w_take   = 1'b0;
        w_drop   = 1'b0;
        w_accept = 1'b0;
        w_clr    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (e_rxdv)
                    w_next = (fs_recv || e_rxd != 8'h55) ? S_SKIP : S_PREAM;
            end
            S_PREAM: begin
                if (!e_rxdv || (e_rxd != 8'h55 && e_rxd != 8'hD5))
                    w_next = S_SKIP;
                else if (e_rxd == 8'hD5) begin
                    w_sfd  = 1'b1;
                    w_next = S_BODY;
                end
            end
            S_BODY: begin
                if (e_rxer) begin
                    w_drop = 1'b1;
                    w_next = e_rxdv ? S_SKIP : S_IDLE;
                end else if (!e_rxdv) begin
                    w_drop = (r_bcnt < MIN_LEN);
                    w_next = w_drop ? S_IDLE : S_CHK;
                end else if (r_bcnt == MAX_LEN) begin
                    w_drop = 1'b1;
                    w_next = S_SKIP;
                end else
                    w_take = 1'b1;
            end
            S_CHK: begin
                w_accept = w_good;
                w_drop   = ~w_good;
                if (e_rxdv)
                    w_next = S_SKIP;
                else
                    w_next = w_good ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (fd_recv) begin
                    w_clr  = 1'b1;
                    w_next = S_IDLE;
                end else if (e_rxdv)
                    w_next = S_SKIP;
            end
            S_SKIP: begin
                // A frame skipped while holding still honours the consumer
                w_clr = fs_recv & fd_recv;
                if (!e_rxdv)
                    w_next = (fs_recv && !fd_recv) ? S_HOLD : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bcnt   <= '0;
            r_bad    <= 1'b0;
            r_bc     <= 1'b0;
            r_uc     <= 1'b0;
            r_op     <= 1'b0;
            r_sha    <= '0;
            r_spa    <= '0;
            fs_recv  <= 1'b0;
            arp_op   <= 1'b0;
            src_mac  <= '0;
            src_ip   <= '0;
            drop_cnt <= '0;
        end else begin
            if (w_sfd) begin
                r_bcnt <= '0;
                r_bad  <= 1'b0;
                r_bc   <= 1'b1;
                r_uc   <= 1'b1;
            end else if (w_take) begin
                r_bcnt <= r_bcnt + 11'd1;
                if (r_bcnt < 11'd6) begin
                    if (e_rxd != 8'hFF)
                        r_bc <= 1'b0;
                    if (e_rxd != w_macb)
                        r_uc <= 1'b0;
                end
                if (w_mis)
                    r_bad <= 1'b1;
                if (r_bcnt == 11'd21)
                    r_op <= (e_rxd == 8'h02);
                if (r_bcnt >= 11'd22 && r_bcnt < 11'd28)
                    r_sha <= {r_sha[39:0], e_rxd};
                if (r_bcnt >= 11'd28 && r_bcnt < 11'd32)
                    r_spa <= {r_spa[23:0], e_rxd};
            end
            if (w_accept) begin
                fs_recv <= 1'b1;
                arp_op  <= r_op;
                src_mac <= r_sha;
                src_ip  <= r_spa;
            end else if (w_clr)
                fs_recv <= 1'b0;
            if (w_drop)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_arp_rx.sv
// tb_arp_rx: randomized ARP frames checked against a frame-level model.
module tb_arp_rx;
    localparam logic [47:0] LMAC = 48'h000A3501FEC0;
    localparam logic [31:0] LIP  = 32'hC0A80002;
    localparam int          MAXL = 1518;
`ifdef ARP_RX_CRC_EN
    localparam int MINL = 46;
    localparam bit CRC  = 1'b1;
`else
    localparam int MINL = 42;
    localparam bit CRC  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        e_rxdv = 1'b0;
    logic [7:0]  e_rxd = 8'h00;
    logic        e_rxer = 1'b0;
    logic        fd_recv = 1'b0;
    logic        fs_recv, arp_op;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] drop_cnt;

    arp_rx dut (
        .clk(clk), .rstn(rstn), .e_rxdv(e_rxdv), .e_rxd(e_rxd),
        .e_rxer(e_rxer), .fs_recv(fs_recv), .fd_recv(fd_recv),
        .arp_op(arp_op), .src_mac(src_mac), .src_ip(src_ip),
        .drop_cnt(drop_cnt)
    );

    always #4 clk = ~clk;

    logic        x_fs = 1'b0, x_op = 1'b0;
    logic [47:0] x_mac = '0;
    logic [31:0] x_ip = '0;
    logic [15:0] x_drop = '0;
    int          vecs = 0, errs = 0;
    bit          chk_en = 1'b0;
    logic [7:0]  fb[$];

    always @(negedge clk) begin
        if (chk_en) begin
            vecs++;
            if ({fs_recv, arp_op, src_mac, src_ip, drop_cnt} !==
                {x_fs, x_op, x_mac, x_ip, x_drop}) begin
                errs++;
                $display("FAIL outputs t=%0t got fs=%b op=%b mac=%h ip=%h drop=%0d want fs=%b op=%b mac=%h ip=%h drop=%0d",
                         $time, fs_recv, arp_op, src_mac, src_ip, drop_cnt,
                         x_fs, x_op, x_mac, x_ip, x_drop);
            end
        end
    end

    task automatic pin(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic tick(input bit dv, input logic [7:0] d,
                        input bit er, input bit fd);
        e_rxdv  = dv;
        e_rxd   = d;
        e_rxer  = er;
        fd_recv = fd;
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--)
            fb.push_back(v[8*i +: 8]);
    endtask

    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, fb[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_arp(input logic [47:0] dm, input logic [15:0] et,
                             input logic [15:0] op, input logic [47:0] sha,
                             input logic [31:0] spa, input logic [31:0] tpa,
                             input int npad, input bit fcs_ok);
        logic [31:0] c;
        fb.delete();
        push_n(64'(dm), 6);
        push_n({$urandom(), $urandom()}, 6);
        push_n(64'(et), 2);
        push_n(64'h0001_0800_0604, 6);
        push_n(64'(op), 2);
        push_n(64'(sha), 6);
        push_n(64'(spa), 4);
        push_n({$urandom(), $urandom()}, 6);
        push_n(64'(tpa), 4);
        for (int i = 0; i < npad; i++)
            fb.push_back(8'($urandom()));
        c = crc_of(fb.size());
        if (!fcs_ok)
            c = c ^ (32'h1 << $urandom_range(31, 0));
        for (int k = 0; k < 4; k++)
            fb.push_back(c[8*k +: 8]);
    endtask

    function automatic bit model_ok(input int len);
        logic [47:0] d;
        logic [31:0] t, fcs;
        bit          ok;
        d = '0;
        t = '0;
        for (int i = 0; i < 6; i++)
            d = {d[39:0], fb[i]};
        for (int i = 38; i < 42; i++)
            t = {t[23:0], fb[i]};
        ok = (d == '1 || d == LMAC) && fb[12] == 8'h08 && fb[13] == 8'h06
          && {fb[14], fb[15], fb[16], fb[17], fb[18], fb[19], fb[20]}
             == 56'h00010800060400
          && (fb[21] == 8'h01 || fb[21] == 8'h02) && t == LIP;
        if (CRC) begin
            fcs = {fb[len-1], fb[len-2], fb[len-3], fb[len-4]};
            ok  = ok && (crc_of(len - 4) == fcs);
        end
        return ok;
    endfunction

    // Frame outcome decided up front; applied at the cycle it must appear
    task automatic send_frame(input int pre, input int len, input int eri);
        int kind, ev;
        kind = 0;
        ev   = -1;
        if (!x_fs) begin
            if (eri >= 0 && eri < len)
                ev = eri;
            if (len > MAXL && (ev < 0 || MAXL < ev))
                ev = MAXL;
            if (ev >= 0)
                kind = 1;
            else if (len < MINL)
                kind = 2;
            else
                kind = 3;
        end
        for (int i = 0; i < pre; i++)
            tick(1'b1, 8'h55, 1'b0, 1'b0);
        tick(1'b1, 8'hD5, 1'b0, 1'b0);
        for (int i = 0; i < len; i++) begin
            tick(1'b1, fb[i], i == eri, 1'b0);
            if (kind == 1 && i == ev)
                x_drop++;
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        if (kind == 2)
            x_drop++;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        if (kind == 3) begin
            if (model_ok(len)) begin
                x_fs  = 1'b1;
                x_op  = (fb[21] == 8'h02);
                x_mac = {fb[22], fb[23], fb[24], fb[25], fb[26], fb[27]};
                x_ip  = {fb[28], fb[29], fb[30], fb[31]};
            end else
                x_drop++;
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic fd_tick();
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        x_fs = 1'b0;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        #2 rstn = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        pin("reset_fs", 64'(fs_recv), 64'd0);
        pin("reset_drop", 64'(drop_cnt), 64'd0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);

        build_arp('1, 16'h0806, 16'h0001, 48'h001122334455,
                  32'hC0A80001, 32'hC0A80002, 18, 1'b1);
        send_frame(7, fb.size(), -1);
        pin("bcast_fs", 64'(fs_recv), 64'd1);
        pin("bcast_op", 64'(arp_op), 64'd0);
        pin("bcast_mac", 64'(src_mac), 64'h001122334455);
        pin("bcast_ip", 64'(src_ip), 64'hC0A80001);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        x_fs = 1'b0;
        pin("fd_clear", 64'(fs_recv), 64'd0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);

        build_arp('1, 16'h0806, 16'h0001, 48'h001122334455,
                  32'hC0A80001, 32'hC0A80003, 18, 1'b1);
        send_frame(7, fb.size(), -1);
        build_arp('1, 16'h0800, 16'h0001, 48'h001122334455,
                  32'hC0A80001, LIP, 18, 1'b1);
        send_frame(7, fb.size(), -1);
        pin("bad_drop", 64'(drop_cnt), 64'd2);
        pin("bad_fs", 64'(fs_recv), 64'd0);

        build_arp(LMAC, 16'h0806, 16'h0002, 48'hAABBCCDDEEFF,
                  32'hC0A80005, LIP, 10, 1'b1);
        send_frame(3, fb.size(), -1);
        pin("reply_op", 64'(arp_op), 64'd1);
        pin("reply_fs", 64'(fs_recv), 64'd1);
        build_arp('1, 16'h0806, 16'h0001, 48'h665544332211,
                  32'hC0A80009, LIP, 18, 1'b1);
        send_frame(7, fb.size(), -1);
        pin("held_mac", 64'(src_mac), 64'hAABBCCDDEEFF);
        pin("held_drop", 64'(drop_cnt), 64'd2);
        fd_tick();

        build_arp('1, 16'h0806, 16'h0001, 48'h001122334455,
                  32'hC0A80001, LIP, 18, 1'b1);
        send_frame(7, fb.size(), 20);
        send_frame(7, 31, -1);
        pin("err_drop", 64'(drop_cnt), 64'd4);
        pin("err_fs", 64'(fs_recv), 64'd0);

        build_arp('1, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F,
                  32'hC0A80007, LIP, 0, 1'b1);
        send_frame(7, MINL - 1, -1);
        pin("short_drop", 64'(drop_cnt), 64'd5);
        send_frame(7, MINL, -1);
        pin("min_fs", 64'(fs_recv), 64'd1);
`ifdef ARP_RX_CRC_EN
        fd_tick();
        build_arp('1, 16'h0806, 16'h0001, 48'h001122334455,
                  32'hC0A80001, LIP, 18, 1'b0);
        send_frame(7, fb.size(), -1);
        pin("fcs_drop", 64'(drop_cnt), 64'd6);
        pin("fcs_fs", 64'(fs_recv), 64'd0);
        build_arp('1, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F,
                  32'hC0A80007, LIP, 18, 1'b1);
        send_frame(7, fb.size(), -1);
        pin("fcs_ok_fs", 64'(fs_recv), 64'd1);
`endif

        // Reset lands mid-frame while a result is still being held
        build_arp('1, 16'h0806, 16'h0001, 48'h001122334455,
                  32'hC0A80001, LIP, 18, 1'b1);
        for (int i = 0; i < 7; i++)
            tick(1'b1, 8'h55, 1'b0, 1'b0);
        tick(1'b1, 8'hD5, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++)
            tick(1'b1, fb[i], 1'b0, 1'b0);
        e_rxd = fb[25];
        rstn  = 1'b0;
        x_fs = 1'b0; x_op = 1'b0; x_mac = '0; x_ip = '0; x_drop = '0;
        #1;
        pin("rst_fs", 64'(fs_recv), 64'd0);
        pin("rst_mac", 64'(src_mac), 64'd0);
        pin("rst_drop", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1;
        tick(1'b1, fb[26], 1'b0, 1'b0);
        rstn = 1'b1;
        for (int i = 27; i < fb.size(); i++)
            tick(1'b1, fb[i], 1'b0, 1'b0);
        repeat (3) tick(1'b0, 8'h00, 1'b0, 1'b0);
        build_arp('1, 16'h0806, 16'h0001, 48'h001122334455,
                  32'hC0A80001, LIP, 18, 1'b1);
        send_frame(7, fb.size(), -1);
        pin("post_rst_ip", 64'(src_ip), 64'hC0A80001);
        fd_tick();

        for (int n = 0; n < 160; n++) begin
            logic [47:0] dm;
            logic [15:0] et, op;
            logic [31:0] tp;
            int          r, len, eri, mi;
            r  = $urandom_range(99, 0);
            dm = (r < 60) ? '1 : (r < 90) ? LMAC
               : 48'({$urandom(), $urandom()});
            et = ($urandom_range(9, 0) == 0) ? 16'h0800 : 16'h0806;
            op = ($urandom_range(19, 0) == 0) ? 16'h0003
               : ($urandom_range(1, 0) == 1) ? 16'h0002 : 16'h0001;
            tp = ($urandom_range(6, 0) == 0) ? (LIP ^ 32'h100) : LIP;
            build_arp(dm, et, op, 48'({$urandom(), $urandom()}),
                      $urandom(), tp, $urandom_range(30, 0),
                      $urandom_range(9, 0) != 0);
            if ($urandom_range(19, 0) == 0) begin
                mi = $urandom_range(20, 14);
                fb[mi] = fb[mi] ^ 8'h10;
            end
            len = fb.size();
            if ($urandom_range(11, 0) == 0)
                len = $urandom_range(fb.size() - 1, 5);
            eri = ($urandom_range(15, 0) == 0) ? $urandom_range(len - 1, 0) : -1;
            send_frame($urandom_range(7, 1), len, eri);
            if ($urandom_range(1, 0) == 1)
                fd_tick();
        end

        fd_tick();
        build_arp('1, 16'h0806, 16'h0001, 48'h00DEADBEEF00,
                  32'hC0A800AA, LIP, MAXL - 46, 1'b1);
        send_frame(7, fb.size(), -1);
        pin("maxlen_fs", 64'(fs_recv), 64'd1);
        fd_tick();
        build_arp('1, 16'h0806, 16'h0001, 48'h00DEADBEEF01,
                  32'hC0A800AB, LIP, MAXL - 45, 1'b1);
        send_frame(7, fb.size(), -1);
        pin("overlen_fs", 64'(fs_recv), 64'd0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
